// File: rtl/piso_serializer.sv
// Parallel-in serial-out converter with a one-word hold buffer so that a
// continuously fed stream leaves sout_valid high with no gaps between words.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PREV = CW'(WIDTH - 2);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [CW-1:0]    r_cnt;
  logic             r_sout;
  logic             r_sout_valid;
  logic             r_last;
  logic             w_accept;

  // Bit that goes out first from a word, in the configured order.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign din_ready  = ~r_hold_full;
  assign w_accept   = din_valid & ~r_hold_full;
  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign last       = r_last;

  // Outputs are computed from the value the shifter takes at this edge,
  // so sout always reflects bit cnt of the word in the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_hold       <= '0;
      r_hold_full  <= 1'b0;
      r_cnt        <= '0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_last       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift      <= din;
            r_cnt        <= '0;
            r_state      <= SHIFT;
            r_sout       <= head(din);
            r_sout_valid <= 1'b1;
            r_last       <= 1'b0;
          end
        end
        SHIFT: begin
          if (r_cnt != CNT_LAST) begin
            r_shift <= step(r_shift);
            r_cnt   <= r_cnt + CW'(1);
            r_sout  <= head(step(r_shift));
            r_last  <= (r_cnt == CNT_PREV);
            if (w_accept) begin
              r_hold      <= din;
              r_hold_full <= 1'b1;
            end
          end else if (r_hold_full) begin
            // din_ready is low here, so the hold buffer cannot be rewritten.
            r_shift     <= r_hold;
            r_cnt       <= '0;
            r_hold_full <= 1'b0;
            r_sout      <= head(r_hold);
            r_last      <= 1'b0;
          end else if (w_accept) begin
            r_shift <= din;
            r_cnt   <= '0;
            r_sout  <= head(din);
            r_last  <= 1'b0;
          end else begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_last       <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: an MSB-first and an LSB-first instance share the same
// stimulus; each task checks its own scenario against hand-computed streams.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       m_ready, m_sout, m_vld, m_last;
  logic       l_ready, l_sout, l_vld, l_last;

  int checks = 0;
  int errors = 0;

  logic [7:0]  q_words [8];
  int          q_start [8];
  int          acc_edge[8];
  int          nwords;
  logic [63:0] rec_ms, rec_mv, rec_ml, rec_mr, rec_ls, rec_lv, rec_ll;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(m_ready), .sout(m_sout), .sout_valid(m_vld), .last(m_last)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(l_ready), .sout(l_sout), .sout_valid(l_vld), .last(l_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents q_words in order (each not before q_start), holding a word until
  // accepted, and records outputs #1 after each of ncyc rising edges.
  task automatic drive_words(input int ncyc);
    int   idx;
    logic acc;
    idx = 0;
    for (int i = 0; i < 8; i++) acc_edge[i] = -1;
    for (int c = 0; c < ncyc; c++) begin
      if (idx < nwords && c >= q_start[idx]) begin
        din       = q_words[idx];
        din_valid = 1'b1;
      end else begin
        din_valid = 1'b0;
      end
      acc = din_valid && m_ready;
      @(posedge clk); #1;
      if (acc) begin
        acc_edge[idx] = c;
        idx++;
      end
      rec_ms[c] = m_sout; rec_mv[c] = m_vld; rec_ml[c] = m_last; rec_mr[c] = m_ready;
      rec_ls[c] = l_sout; rec_lv[c] = l_vld; rec_ll[c] = l_last;
    end
    din_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; din = 8'h00; din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({m_sout, m_vld, m_last, m_ready} !== 4'b0001) begin
      errors++; $display("FAIL reset_msb got %b exp 0001", {m_sout, m_vld, m_last, m_ready});
    end
    checks++; if ({l_sout, l_vld, l_last, l_ready} !== 4'b0001) begin
      errors++; $display("FAIL reset_lsb got %b exp 0001", {l_sout, l_vld, l_last, l_ready});
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_single_word();
    logic [7:0] exp;
    exp = 8'hB0;
    nwords = 1; q_words[0] = 8'hB0; q_start[0] = 0;
    drive_words(11);
    checks++; if (acc_edge[0] !== 0) begin
      errors++; $display("FAIL v1_accept_edge got %0d exp 0", acc_edge[0]);
    end
    for (int c = 0; c < 8; c++) begin
      checks++; if ({rec_mv[c], rec_ms[c], rec_ml[c]} !== {1'b1, exp[7-c], c == 7}) begin
        errors++; $display("FAIL v1_bit%0d got v/s/l %b exp %b", c,
          {rec_mv[c], rec_ms[c], rec_ml[c]}, {1'b1, exp[7-c], c == 7});
      end
    end
    for (int c = 8; c < 11; c++) begin
      checks++; if ({rec_mv[c], rec_ms[c], rec_ml[c]} !== 3'b000) begin
        errors++; $display("FAIL v1_idle%0d got v/s/l %b exp 000", c, {rec_mv[c], rec_ms[c], rec_ml[c]});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp;
    exp = {8'hA5, 8'h3C, 8'h0F};
    nwords = 3;
    q_words[0] = 8'hA5; q_start[0] = 0;
    q_words[1] = 8'h3C; q_start[1] = 0;
    q_words[2] = 8'h0F; q_start[2] = 0;
    drive_words(27);
    checks++; if ({acc_edge[0], acc_edge[1], acc_edge[2]} !== {32'd0, 32'd1, 32'd9}) begin
      errors++; $display("FAIL v3_accept_edges got %0d %0d %0d exp 0 1 9",
        acc_edge[0], acc_edge[1], acc_edge[2]);
    end
    for (int c = 0; c < 24; c++) begin
      checks++; if ({rec_mv[c], rec_ms[c], rec_ml[c]} !== {1'b1, exp[23-c], (c % 8) == 7}) begin
        errors++; $display("FAIL v2_bit%0d got v/s/l %b exp %b", c,
          {rec_mv[c], rec_ms[c], rec_ml[c]}, {1'b1, exp[23-c], (c % 8) == 7});
      end
    end
    for (int c = 1; c < 8; c++) begin
      checks++; if (rec_mr[c] !== 1'b0) begin
        errors++; $display("FAIL v2_ready_hold%0d got %b exp 0", c, rec_mr[c]);
      end
    end
    checks++; if (rec_mr[8] !== 1'b1) begin
      errors++; $display("FAIL v3_ready_after_xfer got %b exp 1", rec_mr[8]);
    end
    checks++; if ({rec_mv[24], rec_ms[24], rec_ml[24]} !== 3'b000) begin
      errors++; $display("FAIL v3_end_idle got v/s/l %b exp 000", {rec_mv[24], rec_ms[24], rec_ml[24]});
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp;
    exp = 8'b0000_1101;  // 1,0,1,1,0,0,0,0 in output order
    nwords = 1; q_words[0] = 8'h0D; q_start[0] = 0;
    drive_words(10);
    for (int c = 0; c < 8; c++) begin
      checks++; if ({rec_lv[c], rec_ls[c], rec_ll[c]} !== {1'b1, exp[c], c == 7}) begin
        errors++; $display("FAIL v4_bit%0d got v/s/l %b exp %b", c,
          {rec_lv[c], rec_ls[c], rec_ll[c]}, {1'b1, exp[c], c == 7});
      end
    end
    checks++; if (rec_lv[8] !== 1'b0) begin
      errors++; $display("FAIL v4_end_idle got %b exp 0", rec_lv[8]);
    end
  endtask

  task automatic test_reset_mid_word();
    int nvld;
    din = 8'h81; din_valid = 1'b1;
    @(posedge clk); #1;
    din = 8'h7E;
    @(posedge clk); #1;
    din_valid = 1'b0;
    checks++; if (m_ready !== 1'b0) begin
      errors++; $display("FAIL v5_hold_full got ready %b exp 0", m_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++; if ({m_sout, m_vld, m_last, m_ready} !== 4'b0001) begin
      errors++; $display("FAIL v5_async_reset got %b exp 0001", {m_sout, m_vld, m_last, m_ready});
    end
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({m_sout, m_vld, m_last, m_ready} !== 4'b0001) begin
      errors++; $display("FAIL v5_reset_held got %b exp 0001", {m_sout, m_vld, m_last, m_ready});
    end
    @(negedge clk); rst = 1'b1;
    nwords = 1; q_words[0] = 8'hFF; q_start[0] = 0;
    drive_words(14);
    checks++; if (acc_edge[0] !== 0) begin
      errors++; $display("FAIL v5_first_edge_accept got %0d exp 0", acc_edge[0]);
    end
    nvld = 0;
    for (int c = 0; c < 14; c++) if (rec_mv[c]) nvld++;
    checks++; if (nvld !== 8) begin
      errors++; $display("FAIL v5_valid_count got %0d exp 8", nvld);
    end
    checks++; if (rec_ms[7:0] !== 8'hFF || rec_mv[7:0] !== 8'hFF) begin
      errors++; $display("FAIL v5_ones got sout %h vld %h exp FF FF", rec_ms[7:0], rec_mv[7:0]);
    end
  endtask

  task automatic test_accept_on_last();
    logic [15:0] exp;
    exp = {8'h96, 8'h5A};
    nwords = 2;
    q_words[0] = 8'h96; q_start[0] = 0;
    q_words[1] = 8'h5A; q_start[1] = 8;
    drive_words(18);
    checks++; if (acc_edge[1] !== 8) begin
      errors++; $display("FAIL v6_accept_edge got %0d exp 8", acc_edge[1]);
    end
    for (int c = 0; c < 16; c++) begin
      checks++; if ({rec_mv[c], rec_ms[c], rec_ml[c]} !== {1'b1, exp[15-c], (c % 8) == 7}) begin
        errors++; $display("FAIL v6_bit%0d got v/s/l %b exp %b", c,
          {rec_mv[c], rec_ms[c], rec_ml[c]}, {1'b1, exp[15-c], (c % 8) == 7});
      end
    end
    checks++; if (rec_mv[16] !== 1'b0) begin
      errors++; $display("FAIL v6_end_idle got %b exp 0", rec_mv[16]);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_lsb_first();
    test_reset_mid_word();
    test_accept_on_last();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
